// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// Grant is held for a whole packet; a watchdog aborts frames whose completion never arrives.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          axi_clk_i,
  input  logic                          axi_a_rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          tx_enable_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_complete_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned   PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned   CW      = (TIMEOUT_WIDTH > 0) ? TIMEOUT_WIDTH : 1;
  localparam logic [CW-1:0] C_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] C_LAST  = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_GAP,
    S_HOLD
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           r_gidx;
  logic [NUM_REQ-1:0]      r_grant;
  logic                    r_tx_enable;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_last_q;
  logic [CW-1:0]           r_cnt;
  logic                    r_tx_cmpl_q;
  logic                    r_timeout;

  logic [PW-1:0]           w_idx [NUM_REQ];
  logic                    w_found;
  logic [PW-1:0]           w_win;
  logic [NUM_REQ-1:0]      w_win_oh;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_cmpl;
  logic                    w_limit;

  // Search order starting at ptr and wrapping: ptr, ptr+1, ..., ptr-1.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx[i] = PW'((32'(r_ptr) + i) % NUM_REQ);
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid_i[w_idx[i]]) begin
        w_found            = 1'b1;
        w_win              = w_idx[i];
        w_win_oh[w_idx[i]] = 1'b1;
      end
    end
  end

  assign w_sel_valid = req_valid_i[r_gidx];
  assign w_sel_last  = req_last_i[r_gidx];
  assign w_sel_data  = req_data_i[r_gidx*DATA_WIDTH +: DATA_WIDTH];

  // Rising-edge completion; a level already high on BUSY entry is not an edge.
  assign w_cmpl  = tx_complete_i & ~r_tx_cmpl_q & (r_state == S_BUSY);
  assign w_limit = (TIMEOUT_CYCLES != 0) && (r_cnt == C_LIMIT);

  always_ff @(posedge axi_clk_i or negedge axi_a_rst_n_i) begin
    if (!axi_a_rst_n_i) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_GRANT;
      S_GRANT: if (w_sel_valid) w_next = S_BUSY;
      S_BUSY:  if (w_cmpl || w_limit) w_next = S_GAP;
      S_GAP:   w_next = (r_timeout || r_last_q) ? S_IDLE : S_HOLD;
      S_HOLD:  if (w_sel_valid) w_next = S_GRANT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk_i or negedge axi_a_rst_n_i) begin
    if (!axi_a_rst_n_i) begin
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_grant     <= '0;
      r_tx_enable <= 1'b0;
      r_tx_data   <= '0;
      r_last_q    <= 1'b0;
      r_cnt       <= '0;
      r_tx_cmpl_q <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_tx_cmpl_q <= tx_complete_i;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gidx  <= w_win;
            r_grant <= w_win_oh;
          end
        end
        S_GRANT: begin
          if (w_sel_valid) begin
            r_tx_data   <= w_sel_data;
            r_last_q    <= w_sel_last;
            r_tx_enable <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_BUSY: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (w_cmpl) begin
            r_tx_enable <= 1'b0;
          end else if (w_limit) begin
            r_tx_enable <= 1'b0;
            r_timeout   <= 1'b1;
            r_grant     <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_timeout || r_last_q) begin
            r_grant <= '0;
            r_ptr   <= (r_gidx == C_LAST) ? '0 : r_gidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_GRANT) ? (r_grant & req_valid_i) : '0;
  assign grant_o     = r_grant;
  assign tx_enable_o = r_tx_enable;
  assign tx_data_o   = r_tx_data;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = r_timeout;

endmodule
